genius_game_controller: RTL and testbench
=========================================

Name: genius_game_controller

Overview:
Top-level game sequencer for the Genius (Simon) game. Drives the index into the pattern-sequence block and plays the current level's prefix on three LEDs. It then checks the player's button presses against the same pattern and advances level, declares a win, or declares a loss. Sits between the player I/O (debounced buttons, LEDs) and the sequence block, whose registered output (`current_number`) it reads back.

Parameters:
- SHOW_TICKS, 8, clock cycles an LED stays lit during playback and during the echo of a correct press (>=1)
- GAP_TICKS, 4, clock cycles all LEDs are dark between shown items (>=1)
- TIMEOUT_TICKS, 64, cycles allowed per player press before loss (>=1)
- MAX_LEVEL, 16, winning level; range 1..16

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level-sensitive start request; rising edge detected internally; also feeds the sequence block's load input
- btn  input  3  debounced player buttons, one-hot per colour (bit0=colour 0 … bit2=colour 2); high for >=1 cycle per press
- seq_number  input  2  pattern value from the sequence block; valid 1 clk after seq_index changes
- seq_index  output  4  pattern position requested from the sequence block
- led  output  3  colour LEDs, one-hot in play; 3'b111 = win
- level  output  5  current level, 0 when idle, 1..MAX_LEVEL in game
- busy  output  1  high in any state except IDLE/WIN/LOSE
- win  output  1  high while in WIN
- lose  output  1  high while in LOSE

Behaviour:
- Reset (async, rst_n=0): state IDLE; seq_index=0, led=0, level=0, busy=0, win=0, lose=0; all timers and the start edge-detect register cleared.
- Start edge: `start_q` is registered and `start & ~start_q` is the start pulse. The pulse is honoured only in IDLE/WIN/LOSE and ignored otherwise.
- Start pulse action: level=1, seq_index=0, win=lose=0, next state FETCH_SHOW.
- FETCH_SHOW, FETCH_IN:
  - Hold seq_index for exactly 2 cycles, covering 1 cycle of sequence-block latency plus 1 cycle of margin.
  - On the 2nd cycle, capture seq_number into `expected`.
  - Go to SHOW or WAIT_IN respectively.
- Colour decode: 0→3'b001, 1→3'b010, 2→3'b100. Value 3 decodes to 3'b000, and any press against it is a mismatch.
- SHOW: led=decode(expected) for SHOW_TICKS cycles, then GAP.
- GAP: led=0 for GAP_TICKS cycles, then:
  - if seq_index==level-1: seq_index=0, go FETCH_IN;
  - else seq_index+1, go FETCH_SHOW.
- WAIT_IN:
  - led=0; the timer counts up from 0 on entry.
  - First cycle with btn!=0:
    - btn==decode(expected) and expected!=3 → ECHO.
    - Otherwise (wrong colour or multi-hot) → LOSE.
  - Timer reaching TIMEOUT_TICKS with btn==0 → LOSE.
  - A press on the same cycle as the timeout wins over the timeout.
- ECHO: led=decode(expected) for SHOW_TICKS cycles, then:
  - if seq_index<level-1: seq_index+1, FETCH_IN;
  - else if level==MAX_LEVEL → WIN;
  - else level+1, seq_index=0, GAP (a dark pause), which then routes to FETCH_SHOW because seq_index(0)!=level-1.
  - Correction for the last case: on level advance, use a dedicated PAUSE state, GAP_TICKS cycles dark, then FETCH_SHOW with seq_index=0.
- btn is ignored in every state except WAIT_IN, including a button held from ECHO into the next WAIT_IN. A press is taken only on a btn rising edge, using registered `btn_q` and `btn & ~btn_q`.
- WIN: led=3'b111, win=1, busy=0. Stays until a start pulse.
- LOSE: led=0, lose=1, busy=0. Stays until a start pulse.
- level counts 1..MAX_LEVEL and never wraps; seq_index never exceeds level-1.
- Reset asserted mid-operation returns to the reset values immediately, regardless of state.

Test Plan:
1. Use SHOW=4, GAP=2, TIMEOUT=20, MAX=16; pattern 2,1,0,1,…; pulse start. Expected:
   - seq_index=0, level=1, busy=1;
   - after 2 cycles led=100 for 4 cycles, then led=0 for 2 cycles;
   - state WAIT_IN with seq_index=0.
2. From 1, press btn=100 → led=100 for 4 cycles, level=2, pause 2 cycles, then playback led 100 (4), 0 (2), 010 (4), 0 (2).
3. From 1, press btn=010 → lose=1, led=000, busy=0. A later start pulse gives level=1 and lose=0.
4. From 1, no press for 20 cycles → lose=1. A press on cycle 20 is accepted instead of a loss.
5. With MAX_LEVEL=2, enter 100 then 100,010 correctly → win=1, led=111, level=2. A start pulse mid-game (before the win) has no effect.
6. Assert rst_n=0 mid-SHOW for 1 cycle → led=0, level=0, seq_index=0 immediately. A btn press while in IDLE produces no change.

Source files
------------

// File: rtl/genius_game_controller.sv
// Genius (Simon) game sequencer: plays the current level's pattern prefix on three LEDs,
// then checks the player's presses against the same pattern and advances, wins or loses.
module genius_game_controller #(
  parameter int SHOW_TICKS    = 8,
  parameter int GAP_TICKS     = 4,
  parameter int TIMEOUT_TICKS = 64,
  parameter int MAX_LEVEL     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] btn,
  input  logic [1:0] seq_number,
  output logic [3:0] seq_index,
  output logic [2:0] led,
  output logic [4:0] level,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH_SHOW, S_SHOW, S_GAP, S_FETCH_IN,
    S_WAIT_IN, S_ECHO, S_PAUSE, S_WIN, S_LOSE
  } state_e;

  localparam int TMAX_A = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int TMAX_B = (TMAX_A > TIMEOUT_TICKS) ? TMAX_A : TIMEOUT_TICKS;
  localparam int TMAX   = (TMAX_B > 2) ? TMAX_B : 2;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] SHOW_LAST  = TW'(SHOW_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_TICKS - 1);
  localparam logic [TW-1:0] FETCH_LAST = TW'(1);

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      idx_q, idx_d;
  logic [4:0]      level_q, level_d;
  logic [1:0]      expected_q, expected_d;
  logic            start_q;
  logic [2:0]      btn_q;

  logic            start_pulse;
  logic [2:0]      btn_rise;
  logic [2:0]      exp_led;
  logic            last_item;

  function automatic logic [2:0] decode(input logic [1:0] v);
    case (v)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  assign start_pulse = start & ~start_q;
  assign btn_rise    = btn & ~btn_q;
  assign exp_led     = decode(expected_q);
  assign last_item   = (idx_q == 4'(level_q - 5'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      level_q    <= '0;
      expected_q <= '0;
      start_q    <= 1'b0;
      btn_q      <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      level_q    <= level_d;
      expected_q <= expected_d;
      start_q    <= start;
      btn_q      <= btn;
    end
  end

  // The timer restarts from 0 on every state change; each timed state leaves on its last tick.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 1'b1;
    idx_d      = idx_q;
    level_d    = level_q;
    expected_d = expected_q;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        timer_d = '0;
        if (start_pulse) begin
          level_d = 5'd1;
          idx_d   = '0;
          state_d = S_FETCH_SHOW;
        end
      end
      S_FETCH_SHOW, S_FETCH_IN: begin
        if (timer_q == FETCH_LAST) begin
          timer_d    = '0;
          expected_d = seq_number;
          state_d    = (state_q == S_FETCH_SHOW) ? S_SHOW : S_WAIT_IN;
        end
      end
      S_SHOW: begin
        if (timer_q == SHOW_LAST) begin
          timer_d = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (last_item) begin
            idx_d   = '0;
            state_d = S_FETCH_IN;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_FETCH_SHOW;
          end
        end
      end
      S_WAIT_IN: begin
        // A press on the timeout cycle still counts as a press.
        if (btn_rise != 3'b000) begin
          timer_d = '0;
          state_d = (btn_rise == exp_led && exp_led != 3'b000) ? S_ECHO : S_LOSE;
        end else if (timer_q == TO_LAST) begin
          timer_d = '0;
          state_d = S_LOSE;
        end
      end
      S_ECHO: begin
        if (timer_q == SHOW_LAST) begin
          timer_d = '0;
          if (!last_item) begin
            idx_d   = idx_q + 4'd1;
            state_d = S_FETCH_IN;
          end else if (level_q == 5'(MAX_LEVEL)) begin
            state_d = S_WIN;
          end else begin
            level_d = level_q + 5'd1;
            idx_d   = '0;
            state_d = S_PAUSE;
          end
        end
      end
      S_PAUSE: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = S_FETCH_SHOW;
        end
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    led  = 3'b000;
    busy = 1'b1;
    win  = 1'b0;
    lose = 1'b0;
    case (state_q)
      S_IDLE:         busy = 1'b0;
      S_SHOW, S_ECHO: led  = exp_led;
      S_WIN: begin
        led  = 3'b111;
        busy = 1'b0;
        win  = 1'b1;
      end
      S_LOSE: begin
        busy = 1'b0;
        lose = 1'b1;
      end
      default: ;
    endcase
  end

  assign seq_index = idx_q;
  assign level     = level_q;

endmodule

// File: tb/tb_genius_game_controller.sv
// Bench for genius_game_controller: random games built as per-cycle expected traces from
// the game rules, replayed against the DUT with a registered pattern-memory model.
module tb_genius_game_controller;

  localparam int SHOW_TICKS    = 4;
  localparam int GAP_TICKS     = 2;
  localparam int TIMEOUT_TICKS = 20;
  localparam int MAX_LEVEL     = 3;
  localparam int W             = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] btn;
  logic [1:0] seq_number = 2'd0;
  logic [3:0] seq_index;
  logic [2:0] led;
  logic [4:0] level;
  logic       busy, win, lose;
  logic [W-1:0] obs;

  logic [1:0]   pattern [16];
  logic [W-1:0] exp_q[$];
  logic [3:0]   stim_q[$];
  string        tag_q[$];
  int           n_checks = 0;
  int           n_errors = 0;

  // Model of where the game stands while a trace is being built.
  int         m_level, m_idx;
  logic [2:0] r_led;
  logic       r_win, r_lose;

  genius_game_controller #(
    .SHOW_TICKS(SHOW_TICKS), .GAP_TICKS(GAP_TICKS),
    .TIMEOUT_TICKS(TIMEOUT_TICKS), .MAX_LEVEL(MAX_LEVEL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .btn(btn), .seq_number(seq_number),
    .seq_index(seq_index), .led(led), .level(level), .busy(busy), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  always @(posedge clk) seq_number <= pattern[seq_index];

  assign obs = {led, level, seq_index, busy, win, lose};

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got led=%b lvl=%0d idx=%0d b/w/l=%b required led=%b lvl=%0d idx=%0d b/w/l=%b",
               tag, got[14:12], got[11:7], got[6:3], got[2:0],
               exp[14:12], exp[11:7], exp[6:3], exp[2:0]);
    end
  endtask

  function automatic logic [2:0] colour(input logic [1:0] v);
    case (v)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] rnd_btn();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic logic rnd_start();
    return ($urandom_range(0, 7) == 0);
  endfunction

  task automatic push(input string tag, input logic [2:0] l, input logic b, input logic w,
                      input logic lo, input logic [2:0] bt, input logic st);
    exp_q.push_back({l, 5'(m_level), 4'(m_idx), b, w, lo});
    stim_q.push_back({st, bt});
    tag_q.push_back(tag);
  endtask

  task automatic push_rest(input int n);
    for (int k = 0; k < n; k++) push("rest", r_led, 1'b0, r_win, r_lose, rnd_btn(), 1'b0);
  endtask

  task automatic set_lose();
    r_led = 3'b000; r_win = 1'b0; r_lose = 1'b1;
  endtask

  // fail_kind: 0 = play to a win, 1 = wrong press at (fail_lv, fail_i), 2 = timeout there.
  task automatic build_game(input int fail_kind, input int fail_lv, input int fail_i);
    logic [2:0] hold, bad, want;
    int d, dmin, r;
    push("start", r_led, 1'b0, r_win, r_lose, 3'b000, 1'b1);
    m_level = 1;
    m_idx   = 0;
    for (int lv = 1; lv <= MAX_LEVEL; lv++) begin
      for (int i = 0; i < lv; i++) begin
        m_idx = i;
        repeat (2) push("fetch_show", 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        repeat (SHOW_TICKS) push("show", colour(pattern[i]), 1'b1, 1'b0, 1'b0, rnd_btn(), rnd_start());
        repeat (GAP_TICKS) push("gap", 3'b000, 1'b1, 1'b0, 1'b0, rnd_btn(), rnd_start());
      end
      for (int i = 0; i < lv; i++) begin
        m_idx = i;
        want  = colour(pattern[i]);
        hold  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        repeat (2) push("fetch_in", 3'b000, 1'b1, 1'b0, 1'b0, hold, 1'b0);
        if (fail_kind == 2 && lv == fail_lv && i == fail_i) begin
          for (int w = 0; w < TIMEOUT_TICKS; w++)
            push("wait_to", 3'b000, 1'b1, 1'b0, 1'b0, (w == 0) ? hold : 3'b000, 1'b0);
          set_lose();
          return;
        end
        dmin = (hold != 3'b000) ? 2 : 0;
        r = $urandom_range(0, 3);
        d = (r == 0) ? dmin : (r == 1) ? TIMEOUT_TICKS - 1 : $urandom_range(dmin, TIMEOUT_TICKS - 1);
        for (int w = 0; w < d; w++)
          push("wait_in", 3'b000, 1'b1, 1'b0, 1'b0, (w == 0) ? hold : 3'b000, 1'b0);
        if ((fail_kind == 1 && lv == fail_lv && i == fail_i) || want == 3'b000) begin
          do bad = 3'($urandom_range(1, 7)); while (bad == want);
          push("bad_press", 3'b000, 1'b1, 1'b0, 1'b0, bad, 1'b0);
          set_lose();
          return;
        end
        push("press", 3'b000, 1'b1, 1'b0, 1'b0, want, 1'b0);
        repeat (SHOW_TICKS) push("echo", want, 1'b1, 1'b0, 1'b0, rnd_btn(), rnd_start());
      end
      if (lv == MAX_LEVEL) begin
        r_led = 3'b111; r_win = 1'b1; r_lose = 1'b0;
        return;
      end
      m_level = lv + 1;
      m_idx   = 0;
      repeat (GAP_TICKS) push("pause", 3'b000, 1'b1, 1'b0, 1'b0, rnd_btn(), rnd_start());
    end
  endtask

  task automatic run_q();
    logic [W-1:0] e;
    logic [3:0]   s;
    string        t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, obs, e);
      start = s[3];
      btn   = s[2:0];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic new_pattern();
    for (int i = 0; i < 16; i++) pattern[i] = 2'($urandom_range(0, 2));
  endtask

  task automatic game(input int kind, input int lv, input int i);
    push_rest($urandom_range(1, 3));
    build_game(kind, lv, i);
    push_rest($urandom_range(1, 3));
    run_q();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    btn   = 3'b000;
    m_level = 0; m_idx = 0;
    r_led = 3'b000; r_win = 1'b0; r_lose = 1'b0;
    new_pattern();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset", obs, '0);
    rst_n = 1'b1;

    // Idle with button noise stays idle.
    push_rest(4);
    run_q();

    game(2, 1, 0);
    game(1, 2, 1);
    game(0, 0, 0);
    game(0, 0, 0);
    game(1, 3, 2);

    pattern[0] = 2'd3;
    game(0, 0, 0);
    new_pattern();

    // Reset in the middle of a shown item.
    push_rest(1);
    push("start", r_led, 1'b0, r_win, r_lose, 3'b000, 1'b1);
    m_level = 1; m_idx = 0;
    repeat (2) push("fetch_show", 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    repeat (2) push("show", colour(pattern[0]), 1'b1, 1'b0, 1'b0, rnd_btn(), 1'b0);
    run_q();
    rst_n = 1'b0;
    start = 1'b0;
    btn   = 3'b000;
    #1;
    check_eq("mid_reset", obs, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_level = 0; m_idx = 0;
    r_led = 3'b000; r_win = 1'b0; r_lose = 1'b0;
    push_rest(3);
    run_q();

    for (int g = 0; g < 6; g++) begin
      int lv;
      new_pattern();
      lv = $urandom_range(1, MAX_LEVEL);
      game($urandom_range(0, 2), lv, $urandom_range(0, lv - 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
